// File: rtl/sram_controller_if.sv
// Bus bundle between the MEM stage, the SRAM controller and the external SRAM.
// The controller connects through the slave modport.
// The pipeline/SRAM side connects through the master modport.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;

  modport slave (
    input  wr_en, rd_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
  );

  modport master (
    output wr_en, rd_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
  );
endinterface

// File: rtl/sram_controller.sv
// Word-wide load/store front end for a 16-bit asynchronous SRAM.
// Each 32-bit access is split into two halfword cycles: low half first, then high half.
// After the two halfword cycles come three settle cycles and a one-cycle DONE handshake.
// The pipeline is frozen (ready=0) for the whole sequence.
module sram_controller (
  input  logic          clk,
  input  logic          rst,
  sram_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  cnt;
  logic        op_write;
  logic [16:0] word;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [17:0] haddr;
  logic        we_n;
  logic        oe;
  logic [15:0] dq_out;
  logic        req;
  logic        ready;
  logic [16:0] word_in;

  // Data window starts at byte 1024; modulo subtraction lets low addresses wrap.
  assign req     = bus.wr_en | bus.rd_en;
  assign word_in = 17'((bus.address - 32'd1024) >> 2);

  assign bus.read_data   = rdata;
  assign bus.ready       = ready;
  assign bus.sram_addr   = haddr;
  assign bus.sram_we_n   = we_n;
  assign bus.sram_dq_out = dq_out;
  assign bus.sram_dq_oe  = oe;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and pipeline-freeze decode.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) state_next = ACCESS;
      end
      ACCESS: begin
        if (cnt == 3'd4) state_next = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, halfword sequencing and registered SRAM pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 3'd0;
      op_write <= 1'b0;
      word     <= 17'd0;
      wdata    <= 32'd0;
      rdata    <= 32'd0;
      haddr    <= 18'd0;
      we_n     <= 1'b1;
      oe       <= 1'b0;
      dq_out   <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            // Store wins when both requests arrive together.
            cnt      <= 3'd0;
            op_write <= bus.wr_en;
            word     <= word_in;
            wdata    <= bus.write_data;
            haddr    <= {word_in, 1'b0};
            if (bus.wr_en) begin
              we_n   <= 1'b0;
              oe     <= 1'b1;
              dq_out <= bus.write_data[15:0];
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd0) begin
            haddr <= {word, 1'b1};
            if (op_write) dq_out           <= wdata[31:16];
            else          rdata[15:0]      <= bus.sram_dq_in;
          end
          if (cnt == 3'd1) begin
            we_n <= 1'b1;
            oe   <= 1'b0;
            if (!op_write) rdata[31:16] <= bus.sram_dq_in;
          end
        end
        DONE: begin
          cnt <= 3'd0;
        end
        default: begin
          cnt <= 3'd0;
        end
      endcase
    end
  end

endmodule
